// File: rtl/triangle_seq.sv
// triangle_seq: sequential point-in-triangle test using one shared sign unit over five cycles.
module triangle_seq #(
   parameter int W  = 11,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  px,
   input  logic [W-1:0]  py,
   input  logic [W-1:0]  p1x,
   input  logic [W-1:0]  p1y,
   input  logic [W-1:0]  p2x,
   input  logic [W-1:0]  p2y,
   input  logic [W-1:0]  p3x,
   input  logic [W-1:0]  p3y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_inside,
   output logic [CW-1:0] tests_cnt,
   output logic [CW-1:0] inside_cnt
);
   localparam int SW = 2*W+3;
   localparam int PW = 2*W+2;
   typedef enum logic [2:0] {IDLE, CALC_D, CALC_A, CALC_B, CALC_C, DONE} state_t;
   state_t state_q;
   logic [W-1:0] px_q, py_q, p1x_q, p1y_q, p2x_q, p2y_q, p3x_q, p3y_q;
   logic signed [SW-1:0] det_q, da_q, db_q;
   logic in_ready_q, out_valid_q, out_inside_q;
   logic [CW-1:0] tests_cnt_q, inside_cnt_q;
   logic [W-1:0] ax, ay, bx, by, cx, cy;
   logic signed [W:0] d_ax, d_ay, d_bx, d_by;
   logic signed [PW-1:0] pr_l, pr_r;
   logic signed [SW-1:0] s;
   logic ok_a, ok_b, ok_c, inside_d;
   // Operand routing for the single sign unit, chosen by the current CALC state
   always_comb begin
      ax = (state_q == CALC_D) ? p1x_q : px_q;
      ay = (state_q == CALC_D) ? p1y_q : py_q;
      bx = (state_q == CALC_D || state_q == CALC_B) ? p2x_q : (state_q == CALC_A) ? p1x_q : p3x_q;
      by = (state_q == CALC_D || state_q == CALC_B) ? p2y_q : (state_q == CALC_A) ? p1y_q : p3y_q;
      cx = (state_q == CALC_D || state_q == CALC_B) ? p3x_q : (state_q == CALC_A) ? p2x_q : p1x_q;
      cy = (state_q == CALC_D || state_q == CALC_B) ? p3y_q : (state_q == CALC_A) ? p2y_q : p1y_q;
   end
   assign d_ax = $signed({1'b0, ax}) - $signed({1'b0, cx});
   assign d_ay = $signed({1'b0, ay}) - $signed({1'b0, cy});
   assign d_bx = $signed({1'b0, bx}) - $signed({1'b0, cx});
   assign d_by = $signed({1'b0, by}) - $signed({1'b0, cy});
   assign pr_l = PW'(d_ax) * PW'(d_by);
   assign pr_r = PW'(d_bx) * PW'(d_ay);
   assign s    = SW'(pr_l) - SW'(pr_r);
   // A zero sub-determinant means the point is on that edge and still counts as inside
   assign ok_a     = (da_q == '0) || (da_q[SW-1] == det_q[SW-1]);
   assign ok_b     = (db_q == '0) || (db_q[SW-1] == det_q[SW-1]);
   assign ok_c     = (s == '0) || (s[SW-1] == det_q[SW-1]);
   assign inside_d = (det_q != '0) && ok_a && ok_b && ok_c;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_inside_q <= 1'b0;
         tests_cnt_q  <= '0;
         inside_cnt_q <= '0;
         det_q        <= '0;
         da_q         <= '0;
         db_q         <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               {px_q, py_q, p1x_q, p1y_q} <= {px, py, p1x, p1y};
               {p2x_q, p2y_q, p3x_q, p3y_q} <= {p2x, p2y, p3x, p3y};
               in_ready_q <= 1'b0;
               state_q    <= CALC_D;
            end
            CALC_D: begin
               det_q   <= s;
               state_q <= CALC_A;
            end
            CALC_A: begin
               da_q    <= s;
               state_q <= CALC_B;
            end
            CALC_B: begin
               db_q    <= s;
               state_q <= CALC_C;
            end
            CALC_C: begin
               out_inside_q <= inside_d;
               out_valid_q  <= 1'b1;
               state_q      <= DONE;
            end
            DONE: if (out_ready) begin
               tests_cnt_q  <= tests_cnt_q + 1'b1;
               inside_cnt_q <= inside_cnt_q + {{(CW-1){1'b0}}, out_inside_q};
               out_valid_q  <= 1'b0;
               in_ready_q   <= 1'b1;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_inside = out_inside_q;
   assign tests_cnt  = tests_cnt_q;
   assign inside_cnt = inside_cnt_q;
endmodule

// File: tb/tb_triangle_seq.sv
// tb_triangle_seq: directed and random point-in-triangle jobs checked against an arithmetic model.
module tb_triangle_seq;
   localparam int W  = 11;
   localparam int CW = 16;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, out_inside;
   logic [W-1:0] px, py, p1x, p1y, p2x, p2y, p3x, p3y;
   logic [CW-1:0] tests_cnt, inside_cnt;
   int n_vec = 0;
   int n_err = 0;
   int exp_tests = 0;
   int exp_inside = 0;
   always #5 clk = ~clk;
   triangle_seq #(.W(W), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .px(px), .py(py), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
      .out_valid(out_valid), .out_ready(out_ready), .out_inside(out_inside),
      .tests_cnt(tests_cnt), .inside_cnt(inside_cnt)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic longint sgn(input longint ax, ay, bx, by, cx, cy);
      return (ax - cx) * (by - cy) - (bx - cx) * (ay - cy);
   endfunction
   function automatic bit agrees(input longint d, input longint det);
      return d == 0 || ((d > 0) == (det > 0));
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic job(input int x, y, x1, y1, x2, y2, x3, y3, input int hold, input bit spur);
      longint det, da, db, dc;
      logic [24:0] det25, da25;
      bit exp_in;
      det = sgn(x1, y1, x2, y2, x3, y3);
      da  = sgn(x, y, x1, y1, x2, y2);
      db  = sgn(x, y, x2, y2, x3, y3);
      dc  = sgn(x, y, x3, y3, x1, y1);
      exp_in = det != 0 && agrees(da, det) && agrees(db, det) && agrees(dc, det);
      det25 = det[24:0];
      da25  = da[24:0];
      chk("in_ready_idle", in_ready, 1);
      {px, py, p1x, p1y} = {W'(x), W'(y), W'(x1), W'(y1)};
      {p2x, p2y, p3x, p3y} = {W'(x2), W'(y2), W'(x3), W'(y3)};
      in_valid = 1'b1;
      step();
      in_valid = spur;
      chk("in_ready_busy", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("out_valid_early", out_valid, 0);
      end
      out_ready = 1'b0;
      step();
      chk("out_valid_done", out_valid, 1);
      chk("out_inside", out_inside, exp_in);
      chk("det", $unsigned(dut.det_q), det25);
      chk("dA", $unsigned(dut.da_q), da25);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", out_valid, 1);
         chk("hold_inside", out_inside, exp_in);
         chk("hold_tests", tests_cnt, CW'(exp_tests));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b0;
      exp_tests  = (exp_tests + 1) % (1 << CW);
      exp_inside = (exp_inside + int'(exp_in)) % (1 << CW);
      chk("post_valid", out_valid, 0);
      chk("post_ready", in_ready, 1);
      chk("tests_cnt", tests_cnt, CW'(exp_tests));
      chk("inside_cnt", inside_cnt, CW'(exp_inside));
   endtask
   initial begin
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      {px, py, p1x, p1y, p2x, p2y, p3x, p3y} = '0;
      step();
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_inside", out_inside, 0);
      chk("rst_tests", tests_cnt, 0);
      chk("rst_inside", inside_cnt, 0);
      chk("rst_det", $unsigned(dut.det_q), 0);
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      job(2, 2, 0, 0, 10, 0, 0, 10, 0, 0);
      job(10, 10, 0, 0, 10, 0, 0, 10, 1, 0);
      job(5, 0, 0, 0, 10, 0, 0, 10, 0, 0);
      job(5, 5, 0, 0, 5, 5, 10, 10, 0, 0);
      job(2047, 2047, 0, 0, 2047, 0, 0, 2047, 0, 0);
      job(3, 1, 0, 0, 10, 0, 0, 10, 3, 1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b0;
      exp_tests = 0;
      exp_inside = 0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_tests", tests_cnt, 0);
      chk("mid_rst_inside", inside_cnt, 0);
      job(2, 2, 0, 0, 10, 0, 0, 10, 0, 0);
      for (int k = 0; k < 40; k++) begin
         int lim;
         lim = (k % 2 == 0) ? 31 : 2047;
         job($urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
             $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
             $urandom_range(0, lim), $urandom_range(0, lim),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
